ttt_game_ctrl: RTL and testbench

Sequential game controller for the tic-tac-toe datapath. It holds the X (AI) and O (player) board registers and drives them into the combinational AI lookup stage. It captures the lookup's one-hot move, validates and applies player moves, and detects win/draw. It sits directly upstream and downstream of the AI lookup: it feeds `x_state`/`o_state` in and consumes `ai_move` back.

---
 rtl/ttt_game_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: owns the X/O boards, sequences AI and player turns, detects win/draw.
// Optional TTT_AI_FALLBACK_EN: an illegal AI move is replaced by the lowest empty cell instead of ending the game.
module ttt_game_ctrl #(
   parameter int AI_WAIT_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       move_valid,
   input  logic [8:0] move_in,
   output logic       move_ready,
   input  logic [8:0] ai_move,
   output logic [8:0] x_state,
   output logic [8:0] o_state,
   output logic       move_err,
   output logic       ai_err,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [2:0] dbg_state
);

   localparam int CW = (AI_WAIT_CYCLES < 2) ? 1 : $clog2(AI_WAIT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(AI_WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      AI_WAIT = 3'd1,
      CHECK_X = 3'd2,
      PLAYER  = 3'd3,
      CHECK_O = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_next;
   logic [8:0]      x_next, o_next, fallback;
   logic [1:0]      winner_next;
   logic            ai_err_next, move_err_next;
   logic [8:0]      occupied;
   logic            board_full;

   // Handshake: a player move transfers on a rising clk edge where move_valid && move_ready.
   // move_ready is high exactly while the FSM sits in PLAYER; an illegal offer is answered by move_err.

   function automatic logic has_line(input logic [8:0] b);
      has_line = (&b[8:6]) | (&b[5:3]) | (&b[2:0])
               | (b[8] & b[5] & b[2]) | (b[7] & b[4] & b[1]) | (b[6] & b[3] & b[0])
               | (b[8] & b[4] & b[0]) | (b[6] & b[4] & b[2]);
   endfunction

   function automatic logic is_one_hot(input logic [8:0] b);
      is_one_hot = (b != 9'd0) && ((b & (b - 9'd1)) == 9'd0);
   endfunction

   assign occupied   = x_state | o_state;
   assign board_full = &occupied;
   assign dbg_state  = state;

   // Lowest-indexed empty cell; scanning downward lets bit 0 win.
   always_comb begin
      fallback = 9'd0;
      for (int i = 8; i >= 0; i--) begin
         if (!occupied[i]) begin
            fallback    = 9'd0;
            fallback[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      x_next        = x_state;
      o_next        = o_state;
      winner_next   = winner;
      ai_err_next   = ai_err;
      move_err_next = 1'b0;
      if (start) begin
         state_next  = AI_WAIT;
         cnt_next    = '0;
         x_next      = 9'd0;
         o_next      = 9'd0;
         winner_next = 2'b00;
         ai_err_next = 1'b0;
      end else begin
         case (state)
            IDLE: ;
            AI_WAIT: begin
               if (cnt == CNT_LAST) begin
                  if (is_one_hot(ai_move) && ((ai_move & occupied) == 9'd0)) begin
                     x_next     = x_state | ai_move;
                     state_next = CHECK_X;
                  end else begin
                     ai_err_next = 1'b1;
`ifdef TTT_AI_FALLBACK_EN
                     x_next      = x_state | fallback;
                     state_next  = CHECK_X;
`else
                     winner_next = 2'b00;
                     state_next  = DONE;
`endif
                  end
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
            CHECK_X: begin
               if (has_line(x_state)) begin
                  winner_next = 2'b01;
                  state_next  = DONE;
               end else if (board_full) begin
                  winner_next = 2'b11;
                  state_next  = DONE;
               end else begin
                  state_next = PLAYER;
               end
            end
            PLAYER: begin
               if (move_valid && move_ready) begin
                  if (is_one_hot(move_in) && ((move_in & occupied) == 9'd0)) begin
                     o_next     = o_state | move_in;
                     state_next = CHECK_O;
                  end else begin
                     move_err_next = 1'b1;
                  end
               end
            end
            CHECK_O: begin
               if (has_line(o_state)) begin
                  winner_next = 2'b10;
                  state_next  = DONE;
               end else if (board_full) begin
                  winner_next = 2'b11;
                  state_next  = DONE;
               end else begin
                  cnt_next   = '0;
                  state_next = AI_WAIT;
               end
            end
            DONE: ;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         x_state    <= 9'd0;
         o_state    <= 9'd0;
         winner     <= 2'b00;
         ai_err     <= 1'b0;
         move_err   <= 1'b0;
         move_ready <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         x_state    <= x_next;
         o_state    <= o_next;
         winner     <= winner_next;
         ai_err     <= ai_err_next;
         move_err   <= move_err_next;
         move_ready <= (state_next == PLAYER);
         game_over  <= (state_next == DONE);
      end
   end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: driver tasks, expected-event queue, negedge monitor, final report.
module tb_ttt_game_ctrl;

   localparam int AW = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       move_valid = 1'b0;
   logic [8:0] move_in = 9'd0;
   logic       move_ready;
   logic [8:0] ai_move = 9'd0;
   logic [8:0] x_state, o_state;
   logic       move_err, ai_err, game_over;
   logic [1:0] winner;
   logic [2:0] dbg_state;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Event record: {code, x_state, o_state, winner, ai_err}; code 1=ready rise, 2=move_err, 3=game_over rise
   logic [22:0] exp_q[$];
   logic        prev_ready = 1'b0;
   logic        prev_go = 1'b0;

   ttt_game_ctrl #(.AI_WAIT_CYCLES(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid), .move_in(move_in),
      .move_ready(move_ready), .ai_move(ai_move), .x_state(x_state), .o_state(o_state),
      .move_err(move_err), .ai_err(ai_err), .game_over(game_over), .winner(winner),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] code, input logic [8:0] x, input logic [8:0] o,
                           input logic [1:0] w, input logic ae);
      exp_q.push_back({code, x, o, w, ae});
   endtask

   task automatic check_event(input logic [1:0] code);
      logic [22:0] obs;
      logic [22:0] exp;
      obs = {code, x_state, o_state, winner, ai_err};
      vec_cnt++;
      if (exp_q.size() == 0) begin
         err_cnt++;
         $display("FAIL unexpected_event: got %h expected none", obs);
      end else begin
         exp = exp_q.pop_front();
         if (obs !== exp) begin
            err_cnt++;
            $display("FAIL event: got %h expected %h", obs, exp);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ready = 1'b0;
         prev_go    = 1'b0;
      end else begin
         if (move_ready && !prev_ready) check_event(2'd1);
         if (move_err) check_event(2'd2);
         if (game_over && !prev_go) check_event(2'd3);
         prev_ready = move_ready;
         prev_go    = game_over;
      end
   end

   task automatic do_start(input logic [8:0] ai);
      @(negedge clk);
      ai_move = ai;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic offer(input logic [8:0] mv);
      int n;
      n = 0;
      @(negedge clk);
      while (!move_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!move_ready) check("ready_timeout", 32'd0, 32'd1);
      move_valid = 1'b1;
      move_in    = mv;
      @(negedge clk);
      move_valid = 1'b0;
      move_in    = 9'd0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      // reset values
      #1;
      check("rst_x", x_state, 0);
      check("rst_o", o_state, 0);
      check("rst_flags", {move_ready, move_err, ai_err, game_over, winner}, 0);
      check("rst_state", dbg_state, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // first AI move and its timing
      push_exp(2'd1, 9'h100, 9'h000, 2'b00, 1'b0);
      @(negedge clk);
      ai_move = 9'h100;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_clear_x", x_state, 0);
      check("start_ai_wait", dbg_state, 1);
      repeat (AW - 1) @(posedge clk);
      #1 check("x_before_sample", x_state, 0);
      @(posedge clk);
      #1 check("x_after_wait", x_state, 9'h100);
      @(posedge clk);
      #1 check("ready_at_player", move_ready, 1);
      check("winner_none", winner, 0);
      drain();

      // rejected player moves
      push_exp(2'd2, 9'h100, 9'h000, 2'b00, 1'b0);
      offer(9'b000000011);
      push_exp(2'd2, 9'h100, 9'h000, 2'b00, 1'b0);
      offer(9'b100000000);
      drain();
      check("ready_after_err", move_ready, 1);

      // X completes top row
      ai_move = 9'h080;
      push_exp(2'd1, 9'h180, 9'h001, 2'b00, 1'b0);
      offer(9'h001);
      drain();
      ai_move = 9'h040;
      push_exp(2'd3, 9'h1C0, 9'h003, 2'b01, 1'b0);
      offer(9'h002);
      drain();
      repeat (10) @(negedge clk);
      check("no_ready_in_done", move_ready, 0);

      // full board, no line
      push_exp(2'd1, 9'h100, 9'h000, 2'b00, 1'b0);
      do_start(9'h100);
      drain();
      ai_move = 9'h040;
      push_exp(2'd1, 9'h140, 9'h010, 2'b00, 1'b0);
      offer(9'h010);
      drain();
      ai_move = 9'h020;
      push_exp(2'd1, 9'h160, 9'h090, 2'b00, 1'b0);
      offer(9'h080);
      drain();
      ai_move = 9'h002;
      push_exp(2'd1, 9'h162, 9'h094, 2'b00, 1'b0);
      offer(9'h004);
      drain();
      ai_move = 9'h001;
      push_exp(2'd3, 9'h163, 9'h09C, 2'b11, 1'b0);
      offer(9'h008);
      drain();
      check("draw_full", x_state | o_state, 9'h1FF);
      check("draw_over", game_over, 1);

      // illegal AI move on first turn
`ifdef TTT_AI_FALLBACK_EN
      push_exp(2'd1, 9'h001, 9'h000, 2'b00, 1'b1);
`else
      push_exp(2'd3, 9'h000, 9'h000, 2'b00, 1'b1);
`endif
      do_start(9'h000);
      drain();

      // mid-game start after three moves
      push_exp(2'd1, 9'h100, 9'h000, 2'b00, 1'b0);
      do_start(9'h100);
      drain();
      ai_move = 9'h040;
      push_exp(2'd1, 9'h140, 9'h010, 2'b00, 1'b0);
      offer(9'h010);
      drain();
      push_exp(2'd1, 9'h001, 9'h000, 2'b00, 1'b0);
      @(negedge clk);
      ai_move = 9'h001;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("abort_x", x_state, 0);
      check("abort_o", o_state, 0);
      check("abort_state", dbg_state, 1);
      check("abort_ready", move_ready, 0);
      drain();

      // asynchronous reset in the middle of AI_WAIT
      ai_move = 9'h100;
      offer(9'h010);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_x", x_state, 0);
      check("arst_o", o_state, 0);
      check("arst_flags", {move_ready, move_err, ai_err, game_over, winner}, 0);
      check("arst_state", dbg_state, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("idle_after_release", dbg_state, 0);

      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
